seq_signed_mul: RTL and testbench

// - Multi-cycle signed multiplier for the datapath: sits downstream of the operand

---
 rtl/seq_signed_mul_pkg.sv | 14 +
 rtl/seq_signed_mul_if.sv | 28 ++
 rtl/seq_signed_mul_cond_negate.sv | 12 +
 rtl/seq_signed_mul.sv | 133 +++++++++++++
 tb/tb_seq_signed_mul.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_signed_mul_pkg.sv
// Shared types and defaults for the sequential signed multiplier.
package seq_signed_mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/seq_signed_mul_if.sv
// Request/result bundle between the datapath and the multiplier.
interface seq_signed_mul_if
    import seq_signed_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 z;
    logic                 n;
    logic                 ovf;

    modport master (
        output start, a, b,
        input  busy, done, product, z, n, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, z, n, ovf
    );

endinterface

// File: rtl/seq_signed_mul_cond_negate.sv
// Two's-complement conditional negation: o_out = i_neg ? -i_in : i_in.
module cond_negate #(
    parameter int N = 32
) (
    input  logic         i_neg,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_out
);

    assign o_out = i_neg ? (~i_in + N'(1)) : i_in;

endmodule

// File: rtl/seq_signed_mul.sv
// Multi-cycle signed multiplier: magnitude shift-add over WIDTH cycles, then sign fix.
module seq_signed_mul
    import seq_signed_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    seq_signed_mul_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW    = 2 * WIDTH;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sgn;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_product;
    logic               r_z;
    logic               r_n;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [PW-1:0]      w_fixed;
    logic [PW-1:0]      w_ma_wide;
    logic [PW-1:0]      w_addend;
    logic               w_last;
    logic [WIDTH:0]     w_upper;
    logic               w_z;
    logic               w_n;
    logic               w_ovf;

    cond_negate #(.N(WIDTH)) u_abs_a (
        .i_neg (r_a[WIDTH-1]),
        .i_in  (r_a),
        .o_out (w_abs_a)
    );

    cond_negate #(.N(WIDTH)) u_abs_b (
        .i_neg (r_b[WIDTH-1]),
        .i_in  (r_b),
        .o_out (w_abs_b)
    );

    cond_negate #(.N(PW)) u_sign_fix (
        .i_neg (r_sgn),
        .i_in  (r_acc),
        .o_out (w_fixed)
    );

    assign w_ma_wide = {{WIDTH{1'b0}}, r_ma};
    assign w_addend  = r_mb[r_cnt] ? (w_ma_wide << r_cnt) : '0;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Low half is a valid signed result only if the top WIDTH+1 bits are a pure sign extension.
    assign w_upper = w_fixed[PW-1:WIDTH-1];
    assign w_z     = (w_fixed == '0);
    assign w_n     = w_fixed[PW-1];
    assign w_ovf   = (|w_upper) && !(&w_upper);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = LOAD;
            LOAD:    w_next = RUN;
            RUN:     if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sgn     <= 1'b0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_sgn <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end
                end
                LOAD: begin
                    r_ma  <= w_abs_a;
                    r_mb  <= w_abs_b;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                RUN: begin
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_product <= w_fixed;
                    r_z       <= w_z;
                    r_n       <= w_n;
                    r_ovf     <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;
    assign bus.z       = r_z;
    assign bus.n       = r_n;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_seq_signed_mul.sv
// Directed bench for seq_signed_mul: latency, signed products, flags, busy/ignore, reset abort.
module tb_seq_signed_mul;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_signed_mul_if #(.WIDTH(32)) bus ();

    seq_signed_mul #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int testsRun;
    int testsFailed;

    // Present one request in cycle 0, scramble a/b after acceptance, wait for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int doneCyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        doneCyc   = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.a     = ~a;
                bus.b     = b + 32'd1;
            end
            if (bus.done === 1'b1) begin
                doneCyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        repeat (2) @(negedge clk);
        testsRun++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        testsRun++;
        if (bus.product !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_product: got %h expected 0", bus.product);
        end
        testsRun++;
        if ({bus.z, bus.n, bus.ovf} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {bus.z, bus.n, bus.ovf});
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        testsRun++;
        if (bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_start_ignored: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int dc;
        run_op(32'd3, 32'd5, dc);
        testsRun++;
        if (dc != 35) begin
            testsFailed++;
            $display("[TB] FAIL basic_latency: got %0d expected 35", dc);
        end
        testsRun++;
        if (bus.product !== 64'h0000_0000_0000_000F) begin
            testsFailed++;
            $display("[TB] FAIL basic_product: got %h expected 000000000000000f", bus.product);
        end
        testsRun++;
        if ({bus.z, bus.n, bus.ovf} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL basic_flags: got %b expected 000", {bus.z, bus.n, bus.ovf});
        end
    endtask

    task automatic test_negative();
        int dc;
        run_op(32'hFFFF_FFF9, 32'd6, dc);
        testsRun++;
        if (dc != 35 || bus.product !== 64'hFFFF_FFFF_FFFF_FFD6) begin
            testsFailed++;
            $display("[TB] FAIL neg_product: got %h at cycle %0d expected ffffffffffffffd6 at 35", bus.product, dc);
        end
        testsRun++;
        if ({bus.z, bus.n, bus.ovf} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL neg_flags: got %b expected 010", {bus.z, bus.n, bus.ovf});
        end
    endtask

    task automatic test_min_min();
        int dc;
        run_op(32'h8000_0000, 32'h8000_0000, dc);
        testsRun++;
        if (dc != 35 || bus.product !== 64'h4000_0000_0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL minmin_product: got %h at cycle %0d expected 4000000000000000 at 35", bus.product, dc);
        end
        testsRun++;
        if ({bus.z, bus.n, bus.ovf} !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL minmin_flags: got %b expected 001", {bus.z, bus.n, bus.ovf});
        end
    endtask

    task automatic test_zero();
        int dc;
        run_op(32'd0, 32'hFFFF_FFFF, dc);
        testsRun++;
        if (dc != 35) begin
            testsFailed++;
            $display("[TB] FAIL zero_latency: got %0d expected 35", dc);
        end
        testsRun++;
        if (bus.product !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL zero_product: got %h expected 0", bus.product);
        end
        testsRun++;
        if ({bus.z, bus.n, bus.ovf} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL zero_flags: got %b expected 100", {bus.z, bus.n, bus.ovf});
        end
    endtask

    task automatic test_ignore_busy();
        int doneCount = 0;
        int busyDrops = 0;
        int heldBad   = 0;
        int idleBusy  = 0;
        logic [63:0] doneProd = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1)  bus.start = 1'b0;
            if (c == 10) begin
                bus.start = 1'b1;
                bus.a     = 32'd9;
                bus.b     = 32'd9;
            end
            if (c == 11) bus.start = 1'b0;
            if (c <= 35 && bus.busy !== 1'b1) busyDrops++;
            if (c > 35 && bus.busy !== 1'b0) idleBusy++;
            if (bus.done === 1'b1) begin
                doneCount++;
                doneProd = bus.product;
            end
            if (c > 35 && bus.product !== 64'd6) heldBad++;
        end
        testsRun++;
        if (doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount);
        end
        testsRun++;
        if (doneProd !== 64'd6) begin
            testsFailed++;
            $display("[TB] FAIL ignore_product: got %h expected 6", doneProd);
        end
        testsRun++;
        if (busyDrops != 0 || idleBusy != 0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_busy: drops=%0d idle_busy=%0d expected 0 0", busyDrops, idleBusy);
        end
        testsRun++;
        if (heldBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_hold: %0d cycles changed expected 0", heldBad);
        end
    endtask

    task automatic test_reset_abort();
        int earlyDone = 0;
        int newDone   = -1;
        logic [63:0] rstProd = '1;
        logic [4:0]  rstCtl  = '1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd4;
        bus.b     = 32'd4;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1)  bus.start = 1'b0;
            if (c == 12) rst = 1'b1;
            if (c == 13) begin
                rstProd   = bus.product;
                rstCtl    = {bus.busy, bus.done, bus.z, bus.n, bus.ovf};
                rst       = 1'b0;
                bus.start = 1'b1;
                bus.a     = 32'd4;
                bus.b     = 32'd4;
            end
            if (c == 14) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                if (c < 48) earlyDone++;
                else if (newDone < 0) newDone = c - 13;
            end
        end
        testsRun++;
        if (rstProd !== 64'd0 || rstCtl !== 5'b00000) begin
            testsFailed++;
            $display("[TB] FAIL abort_outputs: product=%h busy,done,z,n,ovf=%b expected 0 00000", rstProd, rstCtl);
        end
        testsRun++;
        if (earlyDone != 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_done: got %0d early done pulses expected 0", earlyDone);
        end
        testsRun++;
        if (newDone != 35 || bus.product !== 64'd16) begin
            testsFailed++;
            $display("[TB] FAIL abort_restart: latency %0d product %h expected 35 0000000000000010", newDone, bus.product);
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'hFFFF_FFFD;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (c == 37) bus.start = 1'b0;
            if (bus.done === 1'b1) dones.push_back(c);
        end
        testsRun++;
        if (dones.size() != 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count: got %0d done pulses expected 2", dones.size());
        end else if (dones[0] != 35 || dones[1] != 71) begin
            testsFailed++;
            $display("[TB] FAIL b2b_cycles: got %0d,%0d expected 35,71", dones[0], dones[1]);
        end
        testsRun++;
        if (bus.product !== 64'hFFFF_FFFF_FFFF_FFF1 || {bus.z, bus.n, bus.ovf} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL b2b_result: got %h flags %b expected fffffffffffffff1 010", bus.product, {bus.z, bus.n, bus.ovf});
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        test_reset();
        test_basic();
        test_negative();
        test_min_min();
        test_zero();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
